// File: rtl/lfsr_pkg.sv
// Shared types, default constants and next-state functions for the loadable LFSR counter.
// Functions work on a MaxWidth-bit container; callers zero-extend and truncate.
package lfsr_pkg;

    localparam int unsigned MaxWidth = 64;

    localparam logic [7:0]  Taps8       = 8'hB8;
    localparam logic [15:0] Taps16      = 16'hB400;
    localparam logic [7:0]  DefaultSeed = 8'h01;

    typedef enum logic {StIdle, StRun} lfsr_state_e;

    function automatic logic [MaxWidth-1:0] lfsr_fwd(input logic [MaxWidth-1:0] q,
                                                     input logic [MaxWidth-1:0] taps,
                                                     input int unsigned         width);
        logic [MaxWidth-1:0] mask;
        logic                fb;
        mask = {MaxWidth{1'b1}} >> (MaxWidth - width);
        fb   = ^(q & taps & mask);
        return ((q << 1) | MaxWidth'(fb)) & mask;
    endfunction

    // Inverse of lfsr_fwd: the bit shifted out is recovered because the MSB tap is always set.
    function automatic logic [MaxWidth-1:0] lfsr_rev(input logic [MaxWidth-1:0] q,
                                                     input logic [MaxWidth-1:0] taps,
                                                     input int unsigned         width);
        logic [MaxWidth-1:0] mask;
        logic                fb;
        mask = {MaxWidth{1'b1}} >> (MaxWidth - width);
        fb   = q[0] ^ (^((q >> 1) & taps & (mask >> 1)));
        return ((q & mask) >> 1) | (MaxWidth'(fb) << (width - 1));
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR next-state: forward (dir=0) or reverse (dir=1) step of the current value.
module lfsr_step import lfsr_pkg::*; #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = Taps8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt
);

    logic [MaxWidth-1:0] fwd_val;
    logic [MaxWidth-1:0] rev_val;

    always_comb begin
        fwd_val = lfsr_fwd(MaxWidth'(cur), MaxWidth'(TAPS), WIDTH);
        rev_val = lfsr_rev(MaxWidth'(cur), MaxWidth'(TAPS), WIDTH);
        nxt     = dir ? WIDTH'(rev_val) : WIDTH'(fwd_val);
    end

endmodule

// File: rtl/lfsr_counter_load.sv
// Loadable Fibonacci LFSR counter with all-zero load protection and period measurement.
// Define LFSR_DIR_EN to add a dir input allowing reverse stepping.
module lfsr_counter_load import lfsr_pkg::*; #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = Taps8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DefaultSeed)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             cen,
`ifdef LFSR_DIR_EN
    input  logic             dir,
`endif
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             lockup_err,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    logic             step_dir;
    logic [WIDTH-1:0] step_nxt;

`ifdef LFSR_DIR_EN
    assign step_dir = dir;
`else
    assign step_dir = 1'b0;
`endif

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .cur (q),
        .dir (step_dir),
        .nxt (step_nxt)
    );

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            q_q            <= SEED;
            start_q        <= SEED;
            step_cnt_q     <= '0;
            lockup_q       <= 1'b0;
            wrap_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            q_q            <= q_d;
            start_q        <= start_d;
            step_cnt_q     <= step_cnt_d;
            lockup_q       <= lockup_d;
            wrap_q         <= wrap_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        q_d            = q_q;
        start_d        = start_q;
        step_cnt_d     = step_cnt_q;
        lockup_d       = lockup_q;
        wrap_d         = 1'b0;
        period_d       = period_q;
        period_valid_d = period_valid_q;

        if (load) begin
            // An all-zero load would lock the register up; substitute the seed instead.
            q_d        = (data == '0) ? SEED : data;
            start_d    = (data == '0) ? SEED : data;
            lockup_d   = (data == '0);
            step_cnt_d = '0;
            state_d    = StIdle;
        end else if (cen) begin
            q_d     = step_nxt;
            state_d = StRun;
            if (step_dir) begin
                step_cnt_d     = '0;
                period_valid_d = 1'b0;
            end else if (step_nxt == start_q) begin
                wrap_d         = 1'b1;
                period_d       = step_cnt_q + 1'b1;
                period_valid_d = 1'b1;
                step_cnt_d     = '0;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    assign q            = q_q;
    assign lockup_err   = lockup_q;
    assign wrap         = wrap_q & (state_q == StRun);
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_counter_load.sv
// Self-checking bench for lfsr_counter_load: directed test-plan cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_lfsr_counter_load;

    localparam int Taps = 'hB8;
    localparam int Seed = 1;

    logic       clk;
    logic       rst;
    logic       load;
    logic       cen;
    logic       dir;
    logic [7:0] data;
    logic [7:0] q;
    logic       lockup_err;
    logic       wrap;
    logic [7:0] period;
    logic       period_valid;

    lfsr_counter_load dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .cen          (cen),
`ifdef LFSR_DIR_EN
        .dir          (dir),
`endif
        .data         (data),
        .q            (q),
        .lockup_err   (lockup_err),
        .wrap         (wrap),
        .period       (period),
        .period_valid (period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_q, m_start, m_cnt, m_lock, m_wrap, m_per, m_pv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd(input int x);
        int fb;
        fb = $countones(x & Taps) % 2;
        return ((x * 2) + fb) % 256;
    endfunction

    // Predecessor found by exhaustive search of the forward map.
    function automatic int pred(input int x);
        for (int c = 0; c < 256; c++)
            if (fwd(c) == x) return c;
        return -1;
    endfunction

    task automatic model_reset();
        m_q = Seed; m_start = Seed; m_cnt = 0; m_lock = 0; m_wrap = 0; m_per = 0; m_pv = 0;
    endtask

    task automatic model_edge(input logic ld, input logic ce, input logic dr, input int d);
        if (ld) begin
            m_q     = (d == 0) ? Seed : d;
            m_start = m_q;
            m_lock  = (d == 0);
            m_cnt   = 0;
            m_wrap  = 0;
        end else if (ce) begin
            m_wrap = 0;
            if (dr) begin
                m_q   = pred(m_q);
                m_pv  = 0;
                m_cnt = 0;
            end else begin
                m_q = fwd(m_q);
                if (m_q == m_start) begin
                    m_wrap = 1;
                    m_per  = (m_cnt + 1) % 256;
                    m_pv   = 1;
                    m_cnt  = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 256;
                end
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".q"},      32'(q),            32'(m_q));
        check({tag, ".lock"},   32'(lockup_err),   32'(m_lock));
        check({tag, ".wrap"},   32'(wrap),         32'(m_wrap));
        check({tag, ".period"}, 32'(period),       32'(m_per));
        check({tag, ".pv"},     32'(period_valid), 32'(m_pv));
    endtask

    // Apply inputs, take one clock edge, advance the model and compare #1 after the edge.
    task automatic tick(input logic ld, input logic ce, input logic dr, input int d,
                        input string tag);
        load = ld; cen = ce; dir = dr; data = 8'(d);
        @(posedge clk);
        #1;
        model_edge(ld, ce, dr, d);
        compare_model(tag);
    endtask

    initial begin
        int wraps;
        logic dr;
        load = 0; cen = 0; dir = 0; data = 0;
        rst = 1;
        model_reset();
        #1;
        compare_model("reset");
        #13 rst = 0;

        // Forward stepping from 0x10, then pause
        tick(1, 0, 0, 'h10, "load10");
        tick(0, 1, 0, 0, "step1"); check("step1.q", 32'(q), 32'h21);
        tick(0, 1, 0, 0, "step2"); check("step2.q", 32'(q), 32'h43);
        tick(0, 1, 0, 0, "step3"); check("step3.q", 32'(q), 32'h86);
        tick(0, 1, 0, 0, "step4"); check("step4.q", 32'(q), 32'h0D);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, "hold");
            check("hold.q", 32'(q), 32'h0D);
        end

        // All-zero load protection
        tick(1, 0, 0, 0, "load0");
        check("lock.q", 32'(q), 32'h01);
        check("lock.set", 32'(lockup_err), 32'd1);
        tick(1, 0, 0, 'h55, "load55");
        check("lock.clr", 32'(lockup_err), 32'd0);

        // Full maximal-length period
        tick(1, 0, 0, 'h01, "load01");
        wraps = 0;
        for (int i = 1; i <= 255; i++) begin
            tick(0, 1, 0, 0, "period");
            wraps += int'(wrap);
            if (i == 255) begin
                check("period.wrap", 32'(wrap), 32'd1);
                check("period.q", 32'(q), 32'h01);
                check("period.val", 32'(period), 32'd255);
                check("period.pv", 32'(period_valid), 32'd1);
            end
        end
        check("period.wraps", 32'(wraps), 32'd1);
        tick(0, 1, 0, 0, "after_wrap");

        // Load beats cen; load held high keeps q
        tick(1, 1, 0, 'h3C, "prio");
        check("prio.q", 32'(q), 32'h3C);
        for (int i = 0; i < 4; i++) begin
            tick(1, 1'(i % 2), 0, 'h3C, "prio_hold");
            check("prio_hold.q", 32'(q), 32'h3C);
        end

`ifdef LFSR_DIR_EN
        tick(1, 0, 0, 'h10, "dir_load");
        tick(0, 1, 0, 0, "dir_fwd");
        check("dir.fwd", 32'(q), 32'h21);
        tick(0, 1, 1, 0, "dir_rev");
        check("dir.rev", 32'(q), 32'h10);
        check("dir.pv", 32'(period_valid), 32'd0);
        tick(0, 1, 0, 0, "dir_fwd2");
        check("dir.fwd2", 32'(q), 32'h21);
`endif

        // Async reset mid-count, between edges, with lockup flag set
        tick(1, 0, 0, 0, "pre_rst_load");
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, "pre_rst");
        #3 rst = 1;
        #1;
        model_reset();
        compare_model("async_rst");
        @(posedge clk);
        #3 rst = 0;
        compare_model("rst_release");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
`ifdef LFSR_DIR_EN
            dr = ($urandom_range(0, 7) == 0);
`else
            dr = 1'b0;
`endif
            tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0), dr,
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
